// File: rtl/cpu_access_pkg.sv
// Shared types and helpers for the CPU-to-video access acknowledge controller.
// Wait fields up to 16 bits wide and up to 8 channels are supported.
package cpu_access_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SLOT = 2'd1,
      COUNT     = 2'd2,
      ACK       = 2'd3
   } acc_state_e;

   localparam logic [7:0]  TIMEOUT_CYCLES_DEF = 8'd200;
   localparam int unsigned MAX_CH             = 8;
   localparam int unsigned MAX_WAIT_W         = 16;
   localparam int unsigned WAIT_VEC_W         = MAX_CH * MAX_WAIT_W;

   // Extracts field idx of a packed vector of width-bit fields, zero-extended.
   function automatic logic [MAX_WAIT_W-1:0] wait_of(
      input logic [WAIT_VEC_W-1:0] vec,
      input int unsigned           idx,
      input int unsigned           width
   );
      return MAX_WAIT_W'(vec >> (idx * width))
             & ({MAX_WAIT_W{1'b1}} >> (MAX_WAIT_W - width));
   endfunction

endpackage

// File: rtl/prio_enc_onehot.sv
// Lowest-index-wins priority encoder returning both a one-hot vector and the
// binary index of the winning request.
module prio_enc_onehot #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      onehot = '0;
      idx    = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/cpu_access_ack.sv
// 68000 DTACK generator for N memory-mapped video resources with per-channel
// wait states, optional access-slot sync, watchdog and one-hot grant.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no access; samples nAS/CS_N and latches the channel
// WAIT_SLOT | holding off until the latched channel's SLOT pulse
// COUNT     | burning wait states; cnt reaches 1 on the last one
// ACK       | nDTACK asserted until the CPU releases nAS
module cpu_access_ack
   import cpu_access_pkg::*;
#(
   parameter int unsigned            N_CH           = 4,
   parameter int unsigned            WAIT_W         = 4,
   parameter logic [N_CH*WAIT_W-1:0] WAIT_CYCLES    = {N_CH{WAIT_W'(1)}},
   parameter logic [N_CH-1:0]        SLOT_SYNC      = {N_CH{1'b1}},
   parameter int unsigned            TO_W           = 8,
   parameter logic [TO_W-1:0]        TIMEOUT_CYCLES = TO_W'(TIMEOUT_CYCLES_DEF)
) (
   input  logic            clk_main,
   input  logic            reset,
   input  logic            nAS,
   input  logic [N_CH-1:0] CS_N,
   input  logic [N_CH-1:0] SLOT,
   output logic            nDTACK,
   output logic [N_CH-1:0] CH_GRANT,
   output logic            BUSY,
   output logic            TIMEOUT
);

   localparam int unsigned           IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [WAIT_VEC_W-1:0] WAIT_VEC = WAIT_VEC_W'(WAIT_CYCLES);
   // Watchdog fires on the edge where it would count to TIMEOUT_CYCLES.
   localparam logic [TO_W-1:0]       WD_LIMIT = TIMEOUT_CYCLES - TO_W'(1);

   acc_state_e        state, state_n;
   logic [N_CH-1:0]   grant_q, grant_n;
   logic [WAIT_W-1:0] wait_q, wait_n;
   logic [WAIT_W-1:0] cnt, cnt_n;
   logic [TO_W-1:0]   wd, wd_n, wd_inc;
   logic              timeout_q, timeout_n;

   logic [N_CH-1:0]   enc_onehot;
   logic [IDX_W-1:0]  enc_idx;
   logic              enc_any;
   logic [WAIT_W-1:0] wait_sel;
   logic              sync_sel;
   logic              slot_hit;
   logic              wd_hit;
   logic              busy;

   prio_enc_onehot #(
      .N     (N_CH),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req    (~CS_N),
      .onehot (enc_onehot),
      .idx    (enc_idx),
      .any    (enc_any)
   );

   assign wait_sel = WAIT_W'(wait_of(WAIT_VEC, 32'(enc_idx), WAIT_W));
   assign sync_sel = |(SLOT_SYNC & enc_onehot);
   assign slot_hit = |(SLOT & grant_q);
   assign wd_inc   = (wd == {TO_W{1'b1}}) ? wd : wd + TO_W'(1);
   assign wd_hit   = (wd >= WD_LIMIT);

   always_ff @(posedge clk_main) begin
      if (reset) begin
         state     <= IDLE;
         grant_q   <= '0;
         wait_q    <= '0;
         cnt       <= '0;
         wd        <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_n;
         grant_q   <= grant_n;
         wait_q    <= wait_n;
         cnt       <= cnt_n;
         wd        <= wd_n;
         timeout_q <= timeout_n;
      end
   end

   // Priority in the waiting states: abort, then watchdog, then normal progress.
   always_comb begin
      state_n   = state;
      grant_n   = grant_q;
      wait_n    = wait_q;
      cnt_n     = cnt;
      wd_n      = wd;
      timeout_n = 1'b0;

      unique case (state)
         IDLE: begin
            if (!nAS && enc_any) begin
               grant_n = enc_onehot;
               wait_n  = wait_sel;
               cnt_n   = wait_sel;
               wd_n    = '0;
               if (sync_sel)
                  state_n = WAIT_SLOT;
               else if (wait_sel == '0)
                  state_n = ACK;
               else
                  state_n = COUNT;
            end
         end

         WAIT_SLOT: begin
            wd_n = wd_inc;
            if (nAS) begin
               state_n = IDLE;
            end else if (wd_hit) begin
               state_n   = ACK;
               timeout_n = 1'b1;
            end else if (slot_hit) begin
               cnt_n   = wait_q;
               state_n = (wait_q == '0) ? ACK : COUNT;
            end
         end

         COUNT: begin
            wd_n = wd_inc;
            if (nAS) begin
               state_n = IDLE;
            end else if (wd_hit) begin
               state_n   = ACK;
               timeout_n = 1'b1;
            end else if (cnt == WAIT_W'(1)) begin
               state_n = ACK;
            end else begin
               cnt_n = cnt - WAIT_W'(1);
            end
         end

         ACK: begin
            if (nAS)
               state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign BUSY     = busy;
   assign nDTACK   = (state != ACK);
   assign CH_GRANT = busy ? grant_q : '0;
   assign TIMEOUT  = timeout_q;

endmodule
